// File: rtl/hazard_stall_unit.sv
// Decode-stage hazard controller: shadows E/M destinations and tracks a busy mult/div unit.
// Optional stall statistics counter enabled by defining HAZARD_STALL_STATS_EN.
module hazard_stall_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic [1:0]  d_tuse_rs,
    input  logic [1:0]  d_tuse_rt,
    input  logic [4:0]  d_a3,
    input  logic        d_regwe,
    input  logic [1:0]  d_tnew,
    input  logic [1:0]  d_md_kind,
    output logic        stall,
    output logic        de_clr,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    localparam int unsigned MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W  = (MD_MAX == 0) ? 1 : $clog2(MD_MAX + 1);

    localparam logic [1:0] MD_NONE  = 2'b00;
    localparam logic [1:0] MD_MULT  = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] TUSE_NA  = 2'b11;

    logic [4:0]       e_a3_q, e_a3_d;
    logic             e_regwe_q, e_regwe_d;
    logic [1:0]       e_tnew_q, e_tnew_d;
    logic [1:0]       e_md_kind_q, e_md_kind_d;
    logic [4:0]       m_a3_q, m_a3_d;
    logic             m_regwe_q, m_regwe_d;
    logic [1:0]       m_tnew_q, m_tnew_d;
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

    logic rs_hazard_c;
    logic rt_hazard_c;
    logic md_busy_c;
    logic md_hazard_c;
    logic stall_c;

    // Source hazards: an in-flight producer whose result arrives later than D needs it.
    always_comb begin
        rs_hazard_c = 1'b0;
        rt_hazard_c = 1'b0;
        if (d_rs != 5'd0 && d_tuse_rs != TUSE_NA) begin
            if (e_regwe_q && e_a3_q == d_rs && e_tnew_q > d_tuse_rs) rs_hazard_c = 1'b1;
            if (m_regwe_q && m_a3_q == d_rs && m_tnew_q > d_tuse_rs) rs_hazard_c = 1'b1;
        end
        if (d_rt != 5'd0 && d_tuse_rt != TUSE_NA) begin
            if (e_regwe_q && e_a3_q == d_rt && e_tnew_q > d_tuse_rt) rt_hazard_c = 1'b1;
            if (m_regwe_q && m_a3_q == d_rt && m_tnew_q > d_tuse_rt) rt_hazard_c = 1'b1;
        end
    end

    // The unit counts as busy during the E cycle of a mult/div, before the counter loads.
    always_comb begin
        md_busy_c   = !reset && ((md_cnt_q != '0) || (e_md_kind_q == MD_MULT) ||
                                 (e_md_kind_q == MD_DIV));
        md_hazard_c = (d_md_kind != MD_NONE) && md_busy_c;
        stall_c     = !reset && (rs_hazard_c || rt_hazard_c || md_hazard_c);
    end

    assign stall   = stall_c;
    assign de_clr  = stall_c;
    assign md_busy = md_busy_c;

    // Next-state for the pipeline shadows; a stall pushes a bubble into E.
    always_comb begin
        e_a3_d      = d_a3;
        e_regwe_d   = d_regwe;
        e_tnew_d    = d_tnew;
        e_md_kind_d = d_md_kind;
        if (stall_c) begin
            e_a3_d      = 5'd0;
            e_regwe_d   = 1'b0;
            e_tnew_d    = 2'd0;
            e_md_kind_d = MD_NONE;
        end
        m_a3_d    = e_a3_q;
        m_regwe_d = e_regwe_q;
        m_tnew_d  = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;

        md_cnt_d = md_cnt_q;
        if (e_md_kind_q == MD_MULT) begin
            md_cnt_d = CNT_W'(MULT_CYCLES);
        end else if (e_md_kind_q == MD_DIV) begin
            md_cnt_d = CNT_W'(DIV_CYCLES);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_a3_q      <= 5'd0;
            e_regwe_q   <= 1'b0;
            e_tnew_q    <= 2'd0;
            e_md_kind_q <= MD_NONE;
            m_a3_q      <= 5'd0;
            m_regwe_q   <= 1'b0;
            m_tnew_q    <= 2'd0;
            md_cnt_q    <= '0;
        end else begin
            e_a3_q      <= e_a3_d;
            e_regwe_q   <= e_regwe_d;
            e_tnew_q    <= e_tnew_d;
            e_md_kind_q <= e_md_kind_d;
            m_a3_q      <= m_a3_d;
            m_regwe_q   <= m_regwe_d;
            m_tnew_q    <= m_tnew_d;
            md_cnt_q    <= md_cnt_d;
        end
    end

`ifdef HAZARD_STALL_STATS_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else if (stall_c && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule
